am9514_vec_int_engine: RTL and testbench

AM9514_VEC_INT_ENGINE -- requirements
Module: am9514_vec_int_engine

---
 rtl/am9514_vec_int_engine.sv | 192 +++++++++++++++++++
 tb/tb_am9514_vec_int_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am9514_vec_int_engine.sv
// Vector integer engine: LANES elements per beat, registered single-stage output,
// optional per-element masking and saturating ADD/SUB.
module am9514_vec_int_engine #(
    parameter int LANES     = 4,
    parameter int ELEM_W    = 32,
    parameter int MAX_ELEMS = 16,
    localparam int CW = $clog2(MAX_ELEMS) + 1,
    localparam int DW = LANES * ELEM_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           opcode,
    input  logic [CW-1:0]        elem_count,
    input  logic                 mask_en,
    input  logic [MAX_ELEMS-1:0] mask,
    input  logic                 sat_en,
    input  logic                 is_signed,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_a,
    input  logic [DW-1:0]        in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [LANES-1:0]     out_lane_en,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MIN = 3'd2;
    localparam logic [2:0] OP_MAX = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_PA  = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]           op_q;
    logic [CW-1:0]        cnt_q;
    logic                 men_q;
    logic [MAX_ELEMS-1:0] mask_q;
    logic                 sat_q;
    logic                 sgn_q;
    logic [CW-1:0]        beat_q;

    logic                 accept;
    logic                 last_beat;
    logic [DW-1:0]        res;
    logic [LANES-1:0]     lane_en;
    logic                 any_sat;

    // Returns {clamped, result} for one computed lane.
    function automatic logic [ELEM_W:0] lane_op(
        input logic [2:0]        op,
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b,
        input logic              sat,
        input logic              sgn
    );
        logic [ELEM_W:0]   sum;
        logic [ELEM_W:0]   dif;
        logic [ELEM_W-1:0] r;
        logic [ELEM_W-1:0] smax;
        logic [ELEM_W-1:0] smin;
        logic              ovf;
        logic              lt;
        sum  = {1'b0, a} + {1'b0, b};
        dif  = {1'b0, a} - {1'b0, b};
        smax = {1'b0, {(ELEM_W-1){1'b1}}};
        smin = {1'b1, {(ELEM_W-1){1'b0}}};
        lt   = sgn ? ($signed(a) < $signed(b)) : (a < b);
        ovf  = 1'b0;
        r    = '0;
        unique case (op)
            OP_ADD: begin
                r   = sum[ELEM_W-1:0];
                ovf = sgn ? ((a[ELEM_W-1] == b[ELEM_W-1]) && (r[ELEM_W-1] != a[ELEM_W-1]))
                          : sum[ELEM_W];
                if (sat && ovf)
                    r = sgn ? (a[ELEM_W-1] ? smin : smax) : '1;
            end
            OP_SUB: begin
                r   = dif[ELEM_W-1:0];
                ovf = sgn ? ((a[ELEM_W-1] != b[ELEM_W-1]) && (r[ELEM_W-1] != a[ELEM_W-1]))
                          : dif[ELEM_W];
                if (sat && ovf)
                    r = sgn ? (a[ELEM_W-1] ? smin : smax) : '0;
            end
            OP_MIN: r = lt ? a : b;
            OP_MAX: r = lt ? b : a;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_PA:  r = a;
        endcase
        return {sat && ovf, r};
    endfunction

    assign in_ready  = (state_q == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = ((32'(beat_q) + 1) * LANES) >= 32'(cnt_q);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        logic [31:0]          idx;
        logic [MAX_ELEMS-1:0] msh;
        logic [ELEM_W:0]      lr;
        logic [ELEM_W-1:0]    a;
        res     = '0;
        lane_en = '0;
        any_sat = 1'b0;
        idx     = '0;
        msh     = '0;
        lr      = '0;
        a       = '0;
        for (int i = 0; i < LANES; i++) begin
            idx = 32'(beat_q) * LANES + i;
            msh = mask_q >> idx;
            a   = in_a[i*ELEM_W +: ELEM_W];
            lr  = lane_op(op_q, a, in_b[i*ELEM_W +: ELEM_W], sat_q, sgn_q);
            if (idx < 32'(cnt_q)) begin
                lane_en[i] = 1'b1;
                if (!men_q || msh[0]) begin
                    res[i*ELEM_W +: ELEM_W] = lr[ELEM_W-1:0];
                    any_sat = any_sat | lr[ELEM_W];
                end else begin
                    res[i*ELEM_W +: ELEM_W] = a;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (elem_count == '0) ? DONE : RUN;
            RUN:   if (accept && last_beat) state_d = FLUSH;
            FLUSH: if (out_valid && out_ready) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            cnt_q       <= '0;
            men_q       <= 1'b0;
            mask_q      <= '0;
            sat_q       <= 1'b0;
            sgn_q       <= 1'b0;
            beat_q      <= '0;
            sat_flag    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_lane_en <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                op_q     <= opcode;
                cnt_q    <= (elem_count > CW'(MAX_ELEMS)) ? CW'(MAX_ELEMS) : elem_count;
                men_q    <= mask_en;
                mask_q   <= mask;
                sat_q    <= sat_en;
                sgn_q    <= is_signed;
                beat_q   <= '0;
                sat_flag <= 1'b0;
            end
            if (accept) begin
                out_valid   <= 1'b1;
                out_data    <= res;
                out_lane_en <= lane_en;
                beat_q      <= beat_q + CW'(1);
                if (any_sat) sat_flag <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_am9514_vec_int_engine.sv
// Directed and randomized bench for am9514_vec_int_engine (LANES=4, ELEM_W=32, MAX_ELEMS=16).
module tb_am9514_vec_int_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   opcode;
    logic [4:0]   elem_count;
    logic         mask_en;
    logic [15:0]  mask;
    logic         sat_en;
    logic         is_signed;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_a;
    logic [127:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_lane_en;
    logic         busy;
    logic         done;
    logic         sat_flag;

    am9514_vec_int_engine dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .elem_count(elem_count), .mask_en(mask_en), .mask(mask),
        .sat_en(sat_en), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane_en(out_lane_en), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]  va [16];
    logic [31:0]  vb [16];
    logic [127:0] exp_d [4];
    logic [3:0]   exp_e [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: real-number arithmetic, then clamp or wrap to 32 bits.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic sat, input logic sgn);
        longint x, y, r, lo, hi;
        logic f;
        x  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        lo = sgn ? -(64'sd1 <<< 31) : 64'sd0;
        hi = sgn ? (64'sd1 <<< 31) - 1 : (64'sd1 <<< 32) - 1;
        f  = 1'b0;
        case (op)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = (x < y) ? x : y;
            3'd3: r = (x > y) ? x : y;
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = x;
        endcase
        if (sat && op <= 3'd1) begin
            if (r < lo) begin r = lo; f = 1'b1; end
            else if (r > hi) begin r = hi; f = 1'b1; end
        end
        return {f, r[31:0]};
    endfunction

    function automatic logic [31:0] rv();
        unsigned_pick: case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic fill_rand();
        for (int k = 0; k < 16; k++) begin
            va[k] = rv();
            vb[k] = rv();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input int cnt, input logic men,
                          input logic [15:0] msk, input logic sat, input logic sgn,
                          input int stall);
        int eff, nb, in_idx, out_idx, cyc;
        logic exp_sat, stall_prev, fire_prev;
        logic [127:0] pd;
        logic [3:0] pe;
        logic [32:0] m;
        eff = (cnt > 16) ? 16 : cnt;
        nb  = (eff + 3) / 4;
        exp_sat = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0) begin exp_d[k/4] = '0; exp_e[k/4] = '0; end
            if (k < eff) begin
                exp_e[k/4][k%4] = 1'b1;
                if (men && !msk[k]) begin
                    exp_d[k/4][(k%4)*32 +: 32] = va[k];
                end else begin
                    m = model(op, va[k], vb[k], sat, sgn);
                    exp_d[k/4][(k%4)*32 +: 32] = m[31:0];
                    exp_sat = exp_sat | m[32];
                end
            end
        end
        @(negedge clk);
        start = 1'b1; opcode = op; elem_count = 5'(cnt); mask_en = men;
        mask = msk; sat_en = sat; is_signed = sgn; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1'b1);
        if (eff == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_in_ready", in_ready, 1'b0);
            chk("zero_out_valid", out_valid, 1'b0);
            @(negedge clk); #1;
            chk("zero_done_clear", done, 1'b0);
            chk("zero_idle", busy, 1'b0);
            return;
        end
        in_idx = 0; out_idx = 0; cyc = 0;
        stall_prev = 1'b0; fire_prev = 1'b0; pd = '0; pe = '0;
        while (out_idx < nb && cyc < 300) begin
            in_valid = (in_idx < nb) && ($urandom_range(99) >= 20);
            for (int i = 0; i < 4; i++) begin
                in_a[i*32 +: 32] = (in_idx < nb) ? va[in_idx*4+i] : $urandom;
                in_b[i*32 +: 32] = (in_idx < nb) ? vb[in_idx*4+i] : $urandom;
            end
            out_ready  = ($urandom_range(99) >= stall);
            start      = 1'($urandom_range(1));
            opcode     = 3'($urandom);
            elem_count = 5'($urandom);
            #1;
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, pd);
                chk("hold_lane_en", out_lane_en, pe);
            end
            if (fire_prev) chk("latency_valid", out_valid, 1'b1);
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
            fire_prev = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("data_b%0d", out_idx), out_data, exp_d[out_idx]);
                chk($sformatf("lane_en_b%0d", out_idx), out_lane_en, exp_e[out_idx]);
                out_idx++;
            end
            if (fire_prev) in_idx++;
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pe = out_lane_en;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        chk("beats_out", out_idx, nb);
        chk("beats_in", in_idx, nb);
        #1;
        chk("done_pulse", done, 1'b1);
        chk("done_out_valid", out_valid, 1'b0);
        chk("sat_flag", sat_flag, exp_sat);
        @(negedge clk); #1;
        chk("done_clear", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("sat_flag_hold", sat_flag, exp_sat);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; elem_count = '0; mask_en = 1'b0;
        mask = '0; sat_en = 1'b0; is_signed = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sat_flag", sat_flag, 1'b0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_lane_en", out_lane_en, 4'd0);
        @(negedge clk); rst = 1'b0;

        fill_rand();
        for (int k = 0; k < 4; k++) begin va[k] = k + 1; vb[k] = 1; end
        run_op(3'd0, 4, 1'b0, 16'h0, 1'b0, 1'b0, 0);

        fill_rand();
        for (int k = 0; k < 4; k++) begin va[k] = 10 * (k + 1); vb[k] = 1; end
        run_op(3'd0, 4, 1'b1, 16'h0005, 1'b0, 1'b0, 0);

        fill_rand();
        run_op(3'd7, 6, 1'b0, 16'h0, 1'b0, 1'b0, 30);

        fill_rand();
        va[0] = 32'h7FFF_FFFF; vb[0] = 32'h1;
        run_op(3'd0, 1, 1'b0, 16'h0, 1'b1, 1'b1, 0);
        run_op(3'd0, 1, 1'b0, 16'h0, 1'b0, 1'b1, 0);
        va[0] = 32'h0; vb[0] = 32'h1;
        run_op(3'd1, 1, 1'b0, 16'h0, 1'b1, 1'b0, 0);

        fill_rand();
        run_op(3'd0, 16, 1'b0, 16'h0, 1'b1, 1'b1, 75);
        fill_rand();
        run_op(3'd3, 20, 1'b1, 16'hA5C3, 1'b0, 1'b1, 20);

        // Reset in the middle of a saturating operation.
        fill_rand();
        va[0] = 32'h7FFF_FFFF; vb[0] = 32'h1;
        @(negedge clk);
        start = 1'b1; opcode = 3'd0; elem_count = 5'd8; mask_en = 1'b0;
        sat_en = 1'b1; is_signed = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a[i*32 +: 32] = va[i];
            in_b[i*32 +: 32] = vb[i];
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_sat_flag", sat_flag, 1'b0);
        chk("mid_rst_out_data", out_data, 128'd0);
        chk("mid_rst_lane_en", out_lane_en, 4'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_no_beat", out_valid, 1'b0);
        chk("post_rst_idle", busy, 1'b0);
        run_op(3'd0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            fill_rand();
            run_op(3'($urandom), int'($urandom_range(20)), 1'($urandom),
                   16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(60)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
